// File: rtl/csr_arb_pkg.sv
// csr_arb_pkg: shared types and constants for the CSR bus arbiter
package csr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        RESP
    } csr_arb_state_e;

    localparam logic RSP_ERR_TIMEOUT = 1'b1;

    function automatic int tmo_cnt_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

    localparam int TIMEOUT_CNT_W = tmo_cnt_w(16);

endpackage

// File: rtl/csr_bus_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker, nearest requester at or after ptr wins
module rr_arbiter
    import csr_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW:0] cand;

    // Scan offsets from farthest to nearest so the closest requester overwrites idx last
    always_comb begin
        idx  = '0;
        cand = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = {1'b0, ptr} + (IW + 1)'(i);
            if (cand >= (IW + 1)'(N)) cand = cand - (IW + 1)'(N);
            if (req[cand[IW-1:0]]) idx = cand[IW-1:0];
        end
    end

    assign any   = |req;
    assign grant = any ? N'(1) << idx : '0;

endmodule

// File: rtl/csr_bus_arbiter.sv
// csr_bus_arbiter: shares the regblock cpuif port between N_REQ requesters, one transaction at a time
module csr_bus_arbiter
    import csr_arb_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ-1:0]              req_write,
    input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_wdata,
    input  logic [N_REQ*DATA_WIDTH/8-1:0] req_wstrb,
    output logic [N_REQ-1:0]              rsp_valid,
    input  logic [N_REQ-1:0]              rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic                          cpuif_req,
    output logic                          cpuif_req_is_wr,
    output logic [ADDR_WIDTH-1:0]         cpuif_addr,
    output logic [DATA_WIDTH-1:0]         cpuif_wr_data,
    output logic [DATA_WIDTH-1:0]         cpuif_wr_biten,
    input  logic                          cpuif_req_stall_wr,
    input  logic                          cpuif_req_stall_rd,
    input  logic                          cpuif_rd_ack,
    input  logic                          cpuif_rd_err,
    input  logic [DATA_WIDTH-1:0]         cpuif_rd_data,
    input  logic                          cpuif_wr_ack,
    input  logic                          cpuif_wr_err
);

    localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
    localparam int CW = tmo_cnt_w(TIMEOUT_CYCLES);
    localparam int SW = DATA_WIDTH / 8;

    csr_arb_state_e state, state_n;
    logic [IW-1:0] ptr, owner, win;
    logic [N_REQ-1:0] grant;
    logic any;
    logic wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic [SW-1:0] wstrb_q;
    logic err_q;
    logic [CW-1:0] cnt;
    logic stall, ack, ack_err, timeout;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (win),
        .any   (any)
    );

    assign stall   = wr_q ? cpuif_req_stall_wr : cpuif_req_stall_rd;
    assign ack     = wr_q ? cpuif_wr_ack : cpuif_rd_ack;
    assign ack_err = wr_q ? cpuif_wr_err : cpuif_rd_err;
    assign timeout = cnt == CW'(TIMEOUT_CYCLES);

    assign req_ready       = (state == IDLE && !rst) ? grant : '0;
    assign cpuif_req       = state == ISSUE && !stall;
    assign cpuif_req_is_wr = wr_q;
    assign cpuif_addr      = addr_q;
    assign cpuif_wr_data   = wr_q ? wdata_q : '0;
    assign rsp_valid       = state == RESP ? N_REQ'(1) << owner : '0;
    assign rsp_rdata       = rdata_q;
    assign rsp_err         = err_q;

    // Expand byte strobes to bit enables; reads present no enables
    always_comb begin
        cpuif_wr_biten = '0;
        for (int b = 0; b < SW; b++) cpuif_wr_biten[b*8 +: 8] = {8{wr_q & wstrb_q[b]}};
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state: stalls hold ISSUE, watchdog or matching ack ends WAIT_ACK
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:     state_n = any ? ISSUE : IDLE;
            ISSUE:    state_n = stall ? ISSUE : (ack ? RESP : WAIT_ACK);
            WAIT_ACK: state_n = (ack || timeout) ? RESP : WAIT_ACK;
            RESP:     state_n = rsp_ready[owner] ? IDLE : RESP;
            default:  state_n = IDLE;
        endcase
    end

    // Request capture, pointer advance, watchdog and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= '0;
            owner   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            if (state == IDLE && any) begin
                owner   <= win;
                ptr     <= (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
                wr_q    <= req_write[win];
                addr_q  <= req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_q <= req_wdata[win*DATA_WIDTH +: DATA_WIDTH];
                wstrb_q <= req_wstrb[win*SW +: SW];
            end
            if (state == ISSUE && !stall) begin
                cnt <= CW'(1);
                if (ack) begin
                    rdata_q <= (!wr_q && !ack_err) ? cpuif_rd_data : '0;
                    err_q   <= ack_err;
                end
            end
            if (state == WAIT_ACK) begin
                cnt <= cnt + 1'b1;
                if (ack) begin
                    rdata_q <= (!wr_q && !ack_err) ? cpuif_rd_data : '0;
                    err_q   <= ack_err;
                end else if (timeout) begin
                    rdata_q <= '0;
                    err_q   <= RSP_ERR_TIMEOUT;
                end
            end
            if (state == RESP && rsp_ready[owner]) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_csr_bus_arbiter.sv
// tb_csr_bus_arbiter: directed table-driven bench for csr_bus_arbiter with hand sequences for corner cases
module tb_csr_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0, req_ready, req_write = '0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic [7:0]  req_wstrb = '0;
    logic [1:0]  rsp_valid, rsp_ready = '0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        cpuif_req, cpuif_req_is_wr;
    logic [31:0] cpuif_addr, cpuif_wr_data, cpuif_wr_biten;
    logic        cpuif_req_stall_wr = 1'b0, cpuif_req_stall_rd = 1'b0;
    logic        cpuif_rd_ack = 1'b0, cpuif_rd_err = 1'b0;
    logic [31:0] cpuif_rd_data = '0;
    logic        cpuif_wr_ack = 1'b0, cpuif_wr_err = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    csr_bus_arbiter #(.N_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_write          (req_write),
        .req_addr           (req_addr),
        .req_wdata          (req_wdata),
        .req_wstrb          (req_wstrb),
        .rsp_valid          (rsp_valid),
        .rsp_ready          (rsp_ready),
        .rsp_rdata          (rsp_rdata),
        .rsp_err            (rsp_err),
        .cpuif_req          (cpuif_req),
        .cpuif_req_is_wr    (cpuif_req_is_wr),
        .cpuif_addr         (cpuif_addr),
        .cpuif_wr_data      (cpuif_wr_data),
        .cpuif_wr_biten     (cpuif_wr_biten),
        .cpuif_req_stall_wr (cpuif_req_stall_wr),
        .cpuif_req_stall_rd (cpuif_req_stall_rd),
        .cpuif_rd_ack       (cpuif_rd_ack),
        .cpuif_rd_err       (cpuif_rd_err),
        .cpuif_rd_data      (cpuif_rd_data),
        .cpuif_wr_ack       (cpuif_wr_ack),
        .cpuif_wr_err       (cpuif_wr_err)
    );

    typedef struct {
        logic [1:0]  vmask;
        int          r;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          dly;
        logic        aerr;
        logic [31:0] rdin;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [31:0] exp_biten;
    } vec_t;

    vec_t tbl[7];
    vec_t nv;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic clear_ack();
        cpuif_rd_ack = 1'b0;
        cpuif_rd_err = 1'b0;
        cpuif_wr_ack = 1'b0;
        cpuif_wr_err = 1'b0;
    endtask

    // hit=1 drives the matching ack; hit=0 drives an erroring ack of the wrong type
    task automatic drive_ack(input vec_t v, input logic hit);
        cpuif_rd_data = v.rdin;
        cpuif_wr_ack  = v.wr ? hit : !hit;
        cpuif_wr_err  = v.wr ? (v.aerr & hit) : !hit;
        cpuif_rd_ack  = v.wr ? !hit : hit;
        cpuif_rd_err  = v.wr ? !hit : (v.aerr & hit);
    endtask

    task automatic run_txn(input vec_t v);
        logic [1:0] oh;
        oh = 2'b01 << v.r;
        @(negedge clk);
        req_valid = v.vmask;
        req_write = {2{~v.wr}};
        req_write[v.r] = v.wr;
        req_addr = {2{~v.addr}};
        req_addr[v.r*32 +: 32] = v.addr;
        req_wdata = {2{~v.wdata}};
        req_wdata[v.r*32 +: 32] = v.wdata;
        req_wstrb = {2{~v.wstrb}};
        req_wstrb[v.r*4 +: 4] = v.wstrb;
        #1;
        chk("accept_ready", 64'(req_ready), 64'(oh));
        @(negedge clk);
        drive_ack(v, v.dly == 0);
        #1;
        chk("issue_req", 64'(cpuif_req), 64'(1'b1));
        chk("issue_is_wr", 64'(cpuif_req_is_wr), 64'(v.wr));
        chk("issue_addr", 64'(cpuif_addr), 64'(v.addr));
        chk("issue_wdata", 64'(cpuif_wr_data), 64'(v.wr ? v.wdata : 32'h0));
        chk("issue_biten", 64'(cpuif_wr_biten), 64'(v.exp_biten));
        chk("issue_ready", 64'(req_ready), 64'(2'b00));
        for (int d = 1; d <= v.dly; d++) begin
            @(negedge clk);
            drive_ack(v, d == v.dly);
            #1;
            chk("wait_req", 64'(cpuif_req), 64'(1'b0));
        end
        @(negedge clk);
        clear_ack();
        #1;
        chk("resp_valid", 64'(rsp_valid), 64'(oh));
        chk("resp_rdata", 64'(rsp_rdata), 64'(v.exp_rdata));
        chk("resp_err", 64'(rsp_err), 64'(v.exp_err));
        chk("resp_ready", 64'(req_ready), 64'(2'b00));
        rsp_ready = oh;
        @(negedge clk);
        rsp_ready = 2'b00;
        req_valid = 2'b00;
        #1;
        chk("after_resp", 64'(rsp_valid), 64'(2'b00));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        tbl[0] = '{2'b11, 0, 1'b0, 32'h100, 32'h0, 4'h0, 0, 1'b0, 32'h11111111, 32'h11111111, 1'b0, 32'h0};
        tbl[1] = '{2'b11, 1, 1'b0, 32'h104, 32'h0, 4'h0, 1, 1'b0, 32'h22222222, 32'h22222222, 1'b0, 32'h0};
        tbl[2] = '{2'b11, 0, 1'b1, 32'h40000000, 32'hEF, 4'hF, 0, 1'b0, 32'h0, 32'h0, 1'b0, 32'hFFFFFFFF};
        tbl[3] = '{2'b10, 1, 1'b1, 32'h8, 32'hA5A5A5A5, 4'h5, 2, 1'b1, 32'h5A5A5A5A, 32'h0, 1'b1, 32'h00FF00FF};
        tbl[4] = '{2'b01, 0, 1'b0, 32'hC, 32'h0, 4'h0, 3, 1'b1, 32'hDEADBEEF, 32'h0, 1'b1, 32'h0};
        tbl[5] = '{2'b01, 0, 1'b0, 32'h10, 32'h0, 4'h0, 15, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 32'h0};
        tbl[6] = '{2'b10, 1, 1'b1, 32'h14, 32'h01020304, 4'hA, 16, 1'b0, 32'h0, 32'h0, 1'b0, 32'hFF00FF00};

        // reset state, with requests pending
        req_valid = 2'b11;
        #12;
        chk("rst_ready", 64'(req_ready), 64'(2'b00));
        chk("rst_cpuif_req", 64'(cpuif_req), 64'(1'b0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(2'b00));
        chk("rst_addr", 64'(cpuif_addr), 64'(32'h0));
        chk("rst_biten", 64'(cpuif_wr_biten), 64'(32'h0));
        chk("rst_rdata", 64'(rsp_rdata), 64'(32'h0));
        chk("rst_err", 64'(rsp_err), 64'(1'b0));
        @(negedge clk);
        req_valid = 2'b00;
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_txn(tbl[i]);

        // write stalled for 3 cycles; stall must not eat into the watchdog
        @(negedge clk);
        req_valid = 2'b01;
        req_write = 2'b01;
        req_addr = {32'hFFFF_FFFF, 32'h20};
        req_wdata = {32'h0, 32'h55};
        req_wstrb = 8'hF3;
        #1;
        chk("stall_accept", 64'(req_ready), 64'(2'b01));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = 2'b00;
            req_addr = '1;
            req_wdata = '1;
            cpuif_req_stall_wr = 1'b1;
            #1;
            chk("stall_req", 64'(cpuif_req), 64'(1'b0));
            chk("stall_addr", 64'(cpuif_addr), 64'(32'h20));
            chk("stall_wdata", 64'(cpuif_wr_data), 64'(32'h55));
            chk("stall_biten", 64'(cpuif_wr_biten), 64'(32'h0000FFFF));
            chk("stall_is_wr", 64'(cpuif_req_is_wr), 64'(1'b1));
        end
        @(negedge clk);
        cpuif_req_stall_wr = 1'b0;
        cpuif_req_stall_rd = 1'b1;
        #1;
        chk("unstall_req", 64'(cpuif_req), 64'(1'b1));
        chk("unstall_wdata", 64'(cpuif_wr_data), 64'(32'h55));
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            cpuif_req_stall_rd = 1'b0;
            cpuif_wr_ack = (i == 16);
            #1;
            chk("stall_wait", 64'({cpuif_req, rsp_valid}), 64'(3'b000));
        end
        @(negedge clk);
        clear_ack();
        #1;
        chk("stall_rsp_valid", 64'(rsp_valid), 64'(2'b01));
        chk("stall_rsp_err", 64'(rsp_err), 64'(1'b0));
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = 2'b00;
        #1;
        chk("stall_done", 64'(rsp_valid), 64'(2'b00));

        // read never acked: timeout after 16 wait cycles, late acks dropped
        @(negedge clk);
        req_valid = 2'b10;
        req_write = 2'b00;
        req_addr = {32'h44, 32'h0};
        cpuif_rd_data = '1;
        #1;
        chk("to_accept", 64'(req_ready), 64'(2'b10));
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        chk("to_issue", 64'({cpuif_req, cpuif_req_is_wr}), 64'(2'b10));
        chk("to_biten", 64'(cpuif_wr_biten), 64'(32'h0));
        chk("to_wdata", 64'(cpuif_wr_data), 64'(32'h0));
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            #1;
            chk("to_wait", 64'(rsp_valid), 64'(2'b00));
        end
        @(negedge clk);
        #1;
        chk("to_rsp_valid", 64'(rsp_valid), 64'(2'b10));
        chk("to_rsp_err", 64'(rsp_err), 64'(1'b1));
        chk("to_rsp_rdata", 64'(rsp_rdata), 64'(32'h0));
        @(negedge clk);
        cpuif_rd_ack = 1'b1;
        #1;
        chk("late_ack_valid", 64'(rsp_valid), 64'(2'b10));
        @(negedge clk);
        cpuif_rd_ack = 1'b0;
        #1;
        chk("late_ack_rdata", 64'(rsp_rdata), 64'(32'h0));
        chk("late_ack_err", 64'(rsp_err), 64'(1'b1));
        rsp_ready = 2'b10;
        @(negedge clk);
        rsp_ready = 2'b00;
        cpuif_rd_ack = 1'b1;
        cpuif_rd_data = 32'h77;
        #1;
        chk("idle_ack_valid", 64'(rsp_valid), 64'(2'b00));
        @(negedge clk);
        cpuif_rd_ack = 1'b0;
        #1;
        chk("idle_ack_state", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'(0));
        nv = '{2'b01, 0, 1'b0, 32'h18, 32'h0, 4'h0, 0, 1'b0, 32'h600DF00D, 32'h600DF00D, 1'b0, 32'h0};
        run_txn(nv);

        // response back-pressure from owner 1 while requester 0 waits
        @(negedge clk);
        req_valid = 2'b10;
        req_write = 2'b00;
        req_addr = {32'h30, 32'h34};
        #1;
        chk("bp_accept", 64'(req_ready), 64'(2'b10));
        @(negedge clk);
        req_valid = 2'b11;
        cpuif_rd_ack = 1'b1;
        cpuif_rd_data = 32'h13579BDF;
        #1;
        chk("bp_issue", 64'(cpuif_req), 64'(1'b1));
        chk("bp_issue_ready", 64'(req_ready), 64'(2'b00));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cpuif_rd_ack = 1'b0;
            cpuif_rd_data = 32'(i);
            rsp_ready = 2'b01;
            #1;
            chk("bp_valid", 64'(rsp_valid), 64'(2'b10));
            chk("bp_rdata", 64'(rsp_rdata), 64'(32'h13579BDF));
            chk("bp_err", 64'(rsp_err), 64'(1'b0));
            chk("bp_ready0", 64'(req_ready), 64'(2'b00));
        end
        @(negedge clk);
        rsp_ready = 2'b10;
        #1;
        chk("bp_hs_valid", 64'(rsp_valid), 64'(2'b10));
        chk("bp_hs_ready0", 64'(req_ready), 64'(2'b00));
        @(negedge clk);
        rsp_ready = 2'b00;
        req_valid = 2'b01;
        #1;
        chk("bp_next_ready", 64'(req_ready), 64'(2'b01));
        chk("bp_next_valid", 64'(rsp_valid), 64'(2'b00));
        @(negedge clk);
        req_valid = 2'b00;
        cpuif_rd_ack = 1'b1;
        cpuif_rd_data = 32'h2468;
        #1;
        chk("bp2_addr", 64'(cpuif_addr), 64'(32'h34));
        @(negedge clk);
        cpuif_rd_ack = 1'b0;
        #1;
        chk("bp2_rsp", 64'({rsp_valid, rsp_rdata}), 64'({2'b01, 32'h2468}));
        rsp_ready = 2'b01;
        @(negedge clk);
        rsp_ready = 2'b00;

        // reset during WAIT_ACK aborts the transaction and the pointer
        @(negedge clk);
        req_valid = 2'b01;
        req_write = 2'b00;
        req_addr = {32'h0, 32'h50};
        #1;
        chk("abort_accept", 64'(req_ready), 64'(2'b01));
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        chk("abort_issue", 64'(cpuif_req), 64'(1'b1));
        @(negedge clk);
        #1;
        chk("abort_wait", 64'(rsp_valid), 64'(2'b00));
        rst = 1'b1;
        #1;
        chk("abort_req", 64'(cpuif_req), 64'(1'b0));
        chk("abort_addr", 64'(cpuif_addr), 64'(32'h0));
        chk("abort_ready", 64'(req_ready), 64'(2'b00));
        chk("abort_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'(0));
        chk("abort_wr", 64'({cpuif_req_is_wr, cpuif_wr_data, cpuif_wr_biten}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        req_valid = 2'b00;
        nv = '{2'b11, 0, 1'b0, 32'h60, 32'h0, 4'h0, 1, 1'b0, 32'h0BADCAFE, 32'h0BADCAFE, 1'b0, 32'h0};
        run_txn(nv);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
